// File: rtl/dram_ctrl_arbiter.sv
// Purpose : shares one DRAM controller app/wdf/rd interface among num_req_p requesters (round-robin, atomic write bursts).
// Latency : one arbitration cycle before app_en_o; write data and read returns pass through combinationally.
// Backpressure: app_rdy_i / app_wdf_rdy_i forwarded to the granted requester; reads blocked while the ID FIFO is full.
// Optional: define DRAM_CTRL_ARBITER_PERF_EN for saturating per-requester grant counters on grant_cnt_o.
module dram_ctrl_arbiter #(
   parameter int num_req_p       = 2,
   parameter int addr_width_p    = 28,
   parameter int data_width_p    = 128,
   parameter int rd_fifo_depth_p = 8
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [num_req_p-1:0]                   req_en_i,
   input  logic [3*num_req_p-1:0]                 req_cmd_i,
   input  logic [addr_width_p*num_req_p-1:0]      req_addr_i,
   output logic [num_req_p-1:0]                   req_rdy_o,
   input  logic [num_req_p-1:0]                   req_wdf_wren_i,
   input  logic [data_width_p*num_req_p-1:0]      req_wdf_data_i,
   input  logic [(data_width_p/8)*num_req_p-1:0]  req_wdf_mask_i,
   input  logic [num_req_p-1:0]                   req_wdf_end_i,
   output logic [num_req_p-1:0]                   req_wdf_rdy_o,
   output logic [num_req_p-1:0]                   req_rd_valid_o,
   output logic [data_width_p-1:0]                req_rd_data_o,
   output logic                                   req_rd_end_o,
   output logic                                   app_en_o,
   output logic [2:0]                             app_cmd_o,
   output logic [addr_width_p-1:0]                app_addr_o,
   input  logic                                   app_rdy_i,
   output logic                                   app_wdf_wren_o,
   output logic [data_width_p-1:0]                app_wdf_data_o,
   output logic [data_width_p/8-1:0]              app_wdf_mask_o,
   output logic                                   app_wdf_end_o,
   input  logic                                   app_wdf_rdy_i,
   input  logic                                   app_rd_data_valid_i,
   input  logic [data_width_p-1:0]                app_rd_data_i,
   input  logic                                   app_rd_data_end_i,
   output logic [32*num_req_p-1:0]                grant_cnt_o
);

   localparam int GW = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int PW = (rd_fifo_depth_p > 1) ? $clog2(rd_fifo_depth_p) : 1;
   localparam int MW = data_width_p / 8;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [GW-1:0]   r_gnt;
   logic [GW-1:0]   r_rr;
   logic [GW-1:0]   w_pick;
   logic            w_pick_vld;
   logic [num_req_p-1:0] w_elig;
   int              w_idx;

   logic [GW-1:0]   r_fifo_mem [rd_fifo_depth_p];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW:0]     r_count;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_push_ok;
   logic            w_pop;
   logic            w_rd_hit;

   logic [2:0]      w_gnt_cmd;
   logic            w_gnt_en;
   logic            w_cmd_acc;
   logic            w_wr_last;

   assign w_gnt_cmd = req_cmd_i[3*r_gnt +: 3];
   assign w_gnt_en  = req_en_i[r_gnt];
   assign w_cmd_acc = (r_state == S_CMD) & w_gnt_en & app_rdy_i;
   assign w_wr_last = (r_state == S_WDATA) & req_wdf_wren_i[r_gnt] & app_wdf_rdy_i & req_wdf_end_i[r_gnt];

   assign w_full    = (r_count == (PW+1)'(rd_fifo_depth_p));
   assign w_empty   = (r_count == '0);
   assign w_push    = w_cmd_acc & (w_gnt_cmd == CMD_RD);
   assign w_rd_hit  = app_rd_data_valid_i & ~w_empty;
   assign w_pop     = w_rd_hit & app_rd_data_end_i;
   assign w_push_ok = w_push & (~w_full | w_pop);

   // Eligibility: a read may only be granted while the ID FIFO has room
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < num_req_p; i++) begin
         w_elig[i] = req_en_i[i] & ~((req_cmd_i[3*i +: 3] == CMD_RD) & w_full);
      end
   end

   // Round-robin search starting at the rr pointer, wrapping
   always_comb begin
      w_pick     = '0;
      w_pick_vld = 1'b0;
      w_idx      = 0;
      for (int k = 0; k < num_req_p; k++) begin
         w_idx = int'(r_rr) + k;
         if (w_idx >= num_req_p) w_idx = w_idx - num_req_p;
         if (!w_pick_vld && w_elig[w_idx]) begin
            w_pick     = GW'(w_idx);
            w_pick_vld = 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // FSM next state; a dropped req_en_i in CMD abandons the grant
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_pick_vld) w_state_nxt = S_CMD;
         S_CMD: begin
            if (!w_gnt_en)          w_state_nxt = S_IDLE;
            else if (app_rdy_i)     w_state_nxt = (w_gnt_cmd == CMD_RD) ? S_IDLE : S_WDATA;
         end
         S_WDATA: if (w_wr_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: command mux in CMD, write-data passthrough in WDATA
   always_comb begin
      app_en_o       = 1'b0;
      app_cmd_o      = 3'b000;
      app_addr_o     = '0;
      req_rdy_o      = '0;
      app_wdf_wren_o = 1'b0;
      app_wdf_data_o = '0;
      app_wdf_mask_o = '0;
      app_wdf_end_o  = 1'b0;
      req_wdf_rdy_o  = '0;
      case (r_state)
         S_CMD: begin
            app_en_o         = w_gnt_en;
            app_cmd_o        = w_gnt_cmd;
            app_addr_o       = req_addr_i[addr_width_p*r_gnt +: addr_width_p];
            req_rdy_o[r_gnt] = app_rdy_i & w_gnt_en;
         end
         S_WDATA: begin
            app_wdf_wren_o       = req_wdf_wren_i[r_gnt];
            app_wdf_data_o       = req_wdf_data_i[data_width_p*r_gnt +: data_width_p];
            app_wdf_mask_o       = req_wdf_mask_i[MW*r_gnt +: MW];
            app_wdf_end_o        = req_wdf_end_i[r_gnt];
            req_wdf_rdy_o[r_gnt] = app_wdf_rdy_i;
         end
         default: ;
      endcase
   end

   // Grant capture in IDLE; rr pointer advances past the winner on command accept
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_gnt <= '0;
         r_rr  <= '0;
      end else begin
         if (r_state == S_IDLE && w_pick_vld) r_gnt <= w_pick;
         if (w_cmd_acc) r_rr <= (r_gnt == GW'(num_req_p-1)) ? '0 : r_gnt + 1'b1;
      end
   end

   // ID FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // ID FIFO storage (contents need no reset; occupancy guards reads)
   always_ff @(posedge clk_i) begin
      if (w_push_ok) r_fifo_mem[r_wr_ptr] <= r_gnt;
   end

   // Read return steering to the FIFO head; beats with no outstanding read are dropped
   always_comb begin
      req_rd_valid_o = '0;
      for (int i = 0; i < num_req_p; i++) begin
         req_rd_valid_o[i] = w_rd_hit & (r_fifo_mem[r_rd_ptr] == GW'(i));
      end
      req_rd_data_o = w_rd_hit ? app_rd_data_i : '0;
      req_rd_end_o  = w_rd_hit & app_rd_data_end_i;
   end

   // Protocol checks for simulation
   always @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(r_state == S_CMD && !w_gnt_en))
            else $error("dram_ctrl_arbiter: req_en_i dropped before command accept");
         assert (!(app_rd_data_valid_i && w_empty))
            else $error("dram_ctrl_arbiter: read data with no outstanding read");
      end
   end

`ifdef DRAM_CTRL_ARBITER_PERF_EN
   logic [31:0] r_grant_cnt [num_req_p];

   // Saturating accepted-command counters per requester
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < num_req_p; i++) r_grant_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < num_req_p; i++) begin
            if (w_cmd_acc && r_gnt == GW'(i) && r_grant_cnt[i] != 32'hFFFF_FFFF)
               r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
         end
      end
   end

   // Flatten counters onto the output bus
   always_comb begin
      grant_cnt_o = '0;
      for (int i = 0; i < num_req_p; i++) grant_cnt_o[32*i +: 32] = r_grant_cnt[i];
   end
`else
   assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dram_ctrl_arbiter.sv
// Bench for dram_ctrl_arbiter (2 requesters): vector table plus scripted corner cases,
// command/read-return ordering checked against expectation queues.
module tb_dram_ctrl_arbiter;
   localparam int N = 2;
   localparam int A = 28;
   localparam int D = 128;
   localparam int M = D / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      rq_en;
   logic [3*N-1:0]    rq_cmd;
   logic [A*N-1:0]    rq_addr;
   logic [N-1:0]      rq_rdy;
   logic [N-1:0]      rq_wren;
   logic [D*N-1:0]    rq_wdata;
   logic [M*N-1:0]    rq_mask;
   logic [N-1:0]      rq_wend;
   logic [N-1:0]      rq_wrdy;
   logic [N-1:0]      rq_rdv;
   logic [D-1:0]      rq_rdata;
   logic              rq_rend;
   logic              app_en;
   logic [2:0]        app_cmd;
   logic [A-1:0]      app_addr;
   logic              app_rdy;
   logic              app_wren;
   logic [D-1:0]      app_wdata;
   logic [M-1:0]      app_mask;
   logic              app_wend;
   logic              app_wrdy;
   logic              app_rdv;
   logic [D-1:0]      app_rdata;
   logic              app_rend;
   logic [32*N-1:0]   gcnt;

   dram_ctrl_arbiter dut (
      .clk_i(clk), .reset_i(rst),
      .req_en_i(rq_en), .req_cmd_i(rq_cmd), .req_addr_i(rq_addr), .req_rdy_o(rq_rdy),
      .req_wdf_wren_i(rq_wren), .req_wdf_data_i(rq_wdata), .req_wdf_mask_i(rq_mask),
      .req_wdf_end_i(rq_wend), .req_wdf_rdy_o(rq_wrdy),
      .req_rd_valid_o(rq_rdv), .req_rd_data_o(rq_rdata), .req_rd_end_o(rq_rend),
      .app_en_o(app_en), .app_cmd_o(app_cmd), .app_addr_o(app_addr), .app_rdy_i(app_rdy),
      .app_wdf_wren_o(app_wren), .app_wdf_data_o(app_wdata), .app_wdf_mask_o(app_mask),
      .app_wdf_end_o(app_wend), .app_wdf_rdy_i(app_wrdy),
      .app_rd_data_valid_i(app_rdv), .app_rd_data_i(app_rdata), .app_rd_data_end_i(app_rend),
      .grant_cnt_o(gcnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       req;
      logic [2:0] cmd;
      logic [A-1:0] addr;
   } cmd_e_t;

   typedef struct {
      logic [1:0]   en;
      logic         rdy;
      logic         rdv;
      logic         rde;
      logic         exp_en;
      logic [A-1:0] exp_addr;
      logic [1:0]   exp_rdy;
      logic [1:0]   exp_rdv;
   } vec_t;

   cmd_e_t exp_cmd_q[$];
   int     exp_rd_q[$];
   int     n_chk = 0;
   int     n_err = 0;
   logic   hs;
   logic   hs_req;
   vec_t   tbl[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic any_out();
      return |{rq_rdy, rq_wrdy, rq_rdv, rq_rdata, rq_rend, app_en, app_cmd, app_addr,
               app_wren, app_wdata, app_mask, app_wend, gcnt};
   endfunction

   // Scoreboard: pop expected command / read-return on each DUT event
   task automatic monitor();
      cmd_e_t e;
      int     r;
      hs     = app_en & app_rdy;
      hs_req = rq_rdy[1];
      if (hs) begin
         if (exp_cmd_q.size() == 0) chk("cmd_unexpected", {app_cmd, app_addr}, 0);
         else begin
            e = exp_cmd_q.pop_front();
            chk("cmd_order", {rq_rdy, app_cmd, app_addr}, {(e.req ? 2'b10 : 2'b01), e.cmd, e.addr});
         end
      end
      if (rq_rdv != '0) begin
         if (exp_rd_q.size() == 0) chk("rd_unexpected", rq_rdv, 0);
         else begin
            r = exp_rd_q.pop_front();
            chk("rd_steer", rq_rdv, (r == 1) ? 2'b10 : 2'b01);
         end
      end
   endtask

   task automatic settle();
      #3;
      monitor();
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rq_en = '0; rq_cmd = '0; rq_addr = '0; rq_wren = '0; rq_wdata = '0;
      rq_mask = '0; rq_wend = '0; app_rdy = 1'b1; app_wrdy = 1'b1;
      app_rdv = 1'b0; app_rdata = '0; app_rend = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1;
      clear_inputs();
      edge_step();
      settle();
      chk(nm, {63'd0, any_out()}, 0);
      edge_step();
      rst = 1'b0;
   endtask

   // Step until all queued commands issue; requester drops en after its accept edge
   task automatic wait_cmds(input int max_cyc, input string nm);
      int c;
      c = 0;
      while (exp_cmd_q.size() > 0 && c < max_cyc) begin
         settle();
         edge_step();
         if (hs) rq_en[hs_req] = 1'b0;
         c++;
      end
      if (exp_cmd_q.size() > 0) begin
         n_chk++; n_err++;
         $display("FAIL %s: timeout, %0d commands still pending (required 0)", nm, exp_cmd_q.size());
         exp_cmd_q.delete();
      end
   endtask

   task automatic return_beats(input int req, input int n, input logic [D-1:0] dat);
      for (int i = 0; i < n; i++) begin
         exp_rd_q.push_back(req);
         app_rdv = 1'b1; app_rend = 1'b1; app_rdata = dat;
         settle();
         chk("rd_data", {rq_rend, rq_rdata[62:0]}, {1'b1, dat[62:0]});
         edge_step();
      end
      app_rdv = 1'b0; app_rend = 1'b0; app_rdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt0, cnt1, outst;
      tbl[0] = '{2'b11, 1, 0, 0, 0, 28'h0,   2'b00, 2'b00};
      tbl[1] = '{2'b11, 1, 0, 0, 1, 28'h100, 2'b01, 2'b00};
      tbl[2] = '{2'b10, 1, 0, 0, 0, 28'h0,   2'b00, 2'b00};
      tbl[3] = '{2'b10, 1, 0, 0, 1, 28'h200, 2'b10, 2'b00};
      tbl[4] = '{2'b00, 1, 0, 0, 0, 28'h0,   2'b00, 2'b00};
      tbl[5] = '{2'b00, 1, 1, 0, 0, 28'h0,   2'b00, 2'b01};
      tbl[6] = '{2'b00, 1, 1, 1, 0, 28'h0,   2'b00, 2'b01};
      tbl[7] = '{2'b00, 1, 1, 0, 0, 28'h0,   2'b00, 2'b10};
      tbl[8] = '{2'b00, 1, 1, 1, 0, 28'h0,   2'b00, 2'b10};
      tbl[9] = '{2'b00, 1, 0, 0, 0, 28'h0,   2'b00, 2'b00};

      do_reset("reset_outs");

      // Simultaneous reads: 0x100 then 0x200, returns steered 0,0,1,1
      rq_cmd = {3'b001, 3'b001};
      rq_addr[0 +: A] = 28'h100;
      rq_addr[A +: A] = 28'h200;
      exp_cmd_q.push_back('{1'b0, 3'b001, 28'h100});
      exp_cmd_q.push_back('{1'b1, 3'b001, 28'h200});
      exp_rd_q = '{0, 0, 1, 1};
      for (int i = 0; i < 10; i++) begin
         rq_en = tbl[i].en; app_rdy = tbl[i].rdy; app_rdv = tbl[i].rdv; app_rend = tbl[i].rde;
         settle();
         chk($sformatf("vec%0d", i), {app_en, app_addr, rq_rdy, rq_rdv},
             {tbl[i].exp_en, tbl[i].exp_addr, tbl[i].exp_rdy, tbl[i].exp_rdv});
         edge_step();
      end
      app_rdv = 1'b0; app_rend = 1'b0;

      // Write burst from req0 holds off req1's pending read
      rq_cmd = {3'b001, 3'b000};
      rq_addr[0 +: A] = 28'h300;
      rq_addr[A +: A] = 28'h400;
      exp_cmd_q.push_back('{1'b0, 3'b000, 28'h300});
      exp_cmd_q.push_back('{1'b1, 3'b001, 28'h400});
      rq_en = 2'b11; rq_wren = 2'b11; rq_wend = 2'b00;
      rq_wdata[0 +: D] = {8{16'hAAAA}};
      rq_mask[0 +: M]  = 16'h00F0;
      settle();
      chk("wdf_rdy_outside_wdata", rq_wrdy, 0);
      edge_step();
      settle();
      edge_step();
      rq_en[0] = 1'b0;
      app_wrdy = 1'b0;
      settle();
      chk("wdata_stall", {app_en, rq_wrdy, app_wren}, {1'b0, 2'b00, 1'b1});
      edge_step();
      app_wrdy = 1'b1;
      settle();
      chk("wbeat_a", {app_en, rq_wrdy, app_wend, app_mask, app_wdata[31:0]},
          {1'b0, 2'b01, 1'b0, 16'h00F0, 32'hAAAA_AAAA});
      edge_step();
      rq_wdata[0 +: D] = {8{16'hBBBB}};
      rq_wend[0] = 1'b1;
      settle();
      chk("wbeat_b_end", {app_en, rq_wrdy, app_wend, app_wdata[31:0]},
          {1'b0, 2'b01, 1'b1, 32'hBBBB_BBBB});
      edge_step();
      rq_wren = '0; rq_wend = '0;
      settle();
      chk("after_burst_arb", app_en, 0);
      edge_step();
      wait_cmds(4, "pending_read_issue");
      return_beats(1, 1, {4{32'hDEAD_BEEF}});

      // Eight outstanding reads block a ninth until one returns
      rq_cmd = {3'b001, 3'b001};
      for (int k = 0; k < 8; k++) begin
         rq_addr[0 +: A] = 28'h1000 + 28'(k);
         rq_en[0] = 1'b1;
         exp_cmd_q.push_back('{1'b0, 3'b001, 28'h1000 + 28'(k)});
         wait_cmds(6, "fill_fifo");
      end
      rq_addr[0 +: A] = 28'h1008;
      rq_en[0] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         settle();
         chk("full_blocks_read", app_en, 0);
         edge_step();
      end
      exp_cmd_q.push_back('{1'b0, 3'b001, 28'h1008});
      exp_rd_q.push_back(0);
      app_rdv = 1'b1; app_rend = 1'b1;
      settle();
      edge_step();
      app_rdv = 1'b0; app_rend = 1'b0;
      settle();
      chk("unblock_arb_cycle", app_en, 0);
      edge_step();
      settle();
      chk("unblock_issue", {app_en, app_addr}, {1'b1, 28'h1008});
      edge_step();
      rq_en[0] = 1'b0;
      return_beats(0, 8, {4{32'h0123_4567}});

      // Controller not ready for 5 cycles in CMD
      rq_addr[A +: A] = 28'h555;
      rq_en[1] = 1'b1;
      app_rdy = 1'b0;
      exp_cmd_q.push_back('{1'b1, 3'b001, 28'h555});
      settle();
      edge_step();
      for (int c = 0; c < 5; c++) begin
         settle();
         chk("cmd_hold", {app_en, app_addr, rq_rdy}, {1'b1, 28'h555, 2'b00});
         edge_step();
      end
      app_rdy = 1'b1;
      settle();
      chk("rdy_rise", rq_rdy, 2'b10);
      edge_step();
      rq_en[1] = 1'b0;
      return_beats(1, 1, {4{32'hCAFE_F00D}});

      // Fresh reset, then 20 back-to-back reads must alternate 0,1,0,1
      do_reset("reset_outs_2");
      rq_cmd = {3'b001, 3'b001};
      rq_addr[0 +: A] = 28'hA00;
      rq_addr[A +: A] = 28'hB00;
      for (int i = 0; i < 20; i++) begin
         exp_cmd_q.push_back('{1'(i % 2), 3'b001, (i % 2) ? 28'hB00 : 28'hA00});
         exp_rd_q.push_back(i % 2);
      end
      rq_en = 2'b11;
      cnt0 = 0; cnt1 = 0; outst = 0;
      for (int c = 0; c < 200 && (cnt0 + cnt1 < 20 || outst > 0); c++) begin
         if (outst > 0) begin
            app_rdv = 1'b1; app_rend = 1'b1; outst--;
         end else begin
            app_rdv = 1'b0; app_rend = 1'b0;
         end
         settle();
         if (hs) begin
            if (hs_req) cnt1++; else cnt0++;
            outst++;
         end
         edge_step();
         rq_en[0] = (cnt0 < 10);
         rq_en[1] = (cnt1 < 10);
      end
      app_rdv = 1'b0; app_rend = 1'b0;
      chk("alt_cmds_drained", 64'(exp_cmd_q.size()), 0);
      chk("alt_rds_drained", 64'(exp_rd_q.size()), 0);
      exp_cmd_q.delete();
      exp_rd_q.delete();
`ifdef DRAM_CTRL_ARBITER_PERF_EN
      chk("grant_cnt", gcnt, {32'd10, 32'd10});
`else
      chk("grant_cnt_tied", gcnt, 0);
`endif

      // Reset in the middle of a write burst
      rq_en = '0;
      rq_cmd[2:0] = 3'b000;
      rq_addr[0 +: A] = 28'h777;
      rq_en[0] = 1'b1;
      exp_cmd_q.push_back('{1'b0, 3'b000, 28'h777});
      wait_cmds(6, "wr_issue");
      rq_wren[0] = 1'b1; rq_wend[0] = 1'b0;
      rq_wdata[0 +: D] = {8{16'hCCCC}};
      settle();
      chk("in_wdata", {app_wren, app_wdata[15:0]}, {1'b1, 16'hCCCC});
      edge_step();
      rst = 1'b1;
      settle();
      edge_step();
      rst = 1'b0;
      settle();
      chk("rst_mid_write_outs", {63'd0, any_out()}, 0);
      chk("rst_mid_write_gcnt", gcnt, 0);
      edge_step();
      rq_wren = '0;
      settle();
      chk("post_rst_idle", {app_en, app_wren, rq_wrdy}, 0);
      edge_step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/dram_ctrl_arbiter.md
Name: dram_ctrl_arbiter

Overview:
Shares the single DRAM controller user interface (app_* / wdf / rd_data channels) between num_req_p requesters, such as the manycore-link-to-DRAM adapter and the neural-network accelerator in the mesh node.
- Sits between the requesters' DRAM-ctrl-style interfaces and the controller.
- Arbitrates commands round-robin and keeps each write's data burst atomic with its command.
- Steers read data back to the issuing requester in order, using an ID FIFO.

Parameters:
num_req_p, 2, number of requesters (2..4)
addr_width_p, 28, app_addr width
data_width_p, 128, app_wdf_data / app_rd_data width
rd_fifo_depth_p, 8, max outstanding reads (power of 2)

Ports:
clk_i  in  1  single clock
reset_i  in  1  synchronous, active-high reset
req_en_i  in  num_req_p  per-requester command valid
req_cmd_i  in  3*num_req_p  command; 3'b001 = read, 3'b000 = write, other values illegal
req_addr_i  in  addr_width_p*num_req_p  command address
req_rdy_o  out  num_req_p  command accepted this cycle (only the granted requester)
req_wdf_wren_i  in  num_req_p  write beat valid
req_wdf_data_i  in  data_width_p*num_req_p  write beat data
req_wdf_mask_i  in  (data_width_p/8)*num_req_p  byte mask
req_wdf_end_i  in  num_req_p  last write beat
req_wdf_rdy_o  out  num_req_p  write beat accepted
req_rd_valid_o  out  num_req_p  read beat for requester
req_rd_data_o  out  data_width_p  read data (broadcast)
req_rd_end_o  out  1  last read beat (broadcast)
app_en_o, app_cmd_o[2:0], app_addr_o  out  -  to controller
app_rdy_i  in  1  controller command ready
app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o  out  -  to controller
app_wdf_rdy_i  in  1  controller write-data ready
app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i  in  -  from controller
grant_cnt_o  out  32*num_req_p  per-requester grant counters (see Optional Feature)

Behaviour:
- Reset: state = IDLE; rr pointer = 0; FIFO empty; all *_o = 0.
- FSM states: IDLE, CMD, WDATA.
- IDLE:
  - Eligible requester = req_en_i set, and, if the command is a read, the ID FIFO is not full.
  - Pick the first eligible requester at or after the rr pointer, wrapping.
  - Register the grant and go to CMD next cycle. The arbitration cycle adds one cycle of latency.
  - No eligible requester: stay in IDLE.
- CMD:
  - Drive app_en_o=1 and mux the granted requester's cmd/addr to the app_* outputs.
  - req_rdy_o[g] = app_rdy_i.
  - On app_en_o & app_rdy_i:
    - rr pointer = g+1 mod num_req_p.
    - Read: push g into the ID FIFO and return to IDLE.
    - Write: go to WDATA.
- WDATA:
  - Pass the granted requester's wdf signals straight through to app_wdf_*.
  - req_wdf_rdy_o[g] = app_wdf_rdy_i.
  - On wren & rdy & end: return to IDLE.
  - The grant is held for the whole write; no other command is issued.
- A requester deasserting req_en_i in CMD before acceptance is a protocol violation. Simulation $error; the hardware returns to IDLE.
- Read return:
  - req_rd_valid_o = onehot(FIFO head) & app_rd_data_valid_i.
  - Data and end are passed combinationally, zero latency.
  - Pop the FIFO on app_rd_data_valid_i & app_rd_data_end_i.
- FIFO edge cases:
  - Simultaneous push and pop is legal when full; the count is unchanged.
  - Read data arriving with the FIFO empty is a simulation $error; the beat is dropped.
- Reset mid-write: the controller side is reset together with the arbiter, so no partial-burst recovery is required.
- Requesters with req_wdf_wren_i asserted outside WDATA see req_wdf_rdy_o = 0.

Optional Feature:
Macro DRAM_CTRL_ARBITER_PERF_EN.
- Defined:
  - grant_cnt_o[i] increments on each accepted command of requester i.
  - The counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: grant_cnt_o is tied to 0 and no counter flops are synthesized.

Test Plan:
- Both requesters issue reads to 0x100 (req0) and 0x200 (req1) simultaneously after reset, with app_rdy_i=1 → app_addr_o order is 0x100 then 0x200. Two 2-beat responses assert req_rd_valid_o[0] twice, then req_rd_valid_o[1] twice.
- req0 writes 2 beats (0xA.., 0xB..) while req1 holds a pending read → no app_en_o pulse for req1 until req0's beat with end=1 is accepted; req1's read is then issued.
- 8 outstanding reads from req0 with no returns → a 9th read is not granted. When one end beat returns, the 9th read issues the next arbitration cycle.
- app_rdy_i held low 5 cycles in CMD → app_en_o stays high with stable addr; req_rdy_o[g] rises only in the cycle app_rdy_i=1.
- Continuous requests from both requesters for 20 commands → grants strictly alternate 0,1,0,1. With DRAM_CTRL_ARBITER_PERF_EN, grant_cnt_o shows 10 and 10.
- Reset asserted while in WDATA → next cycle state=IDLE, all outputs 0, FIFO empty, grant_cnt_o=0.
